vend_change_ctrl: RTL and testbench

Change-dispensing controller for the vending machine. After a sale, it takes a change amount through a valid/ready handshake and sequences the coin ejector, one coin per clock. Coin selection is greedy, largest denomination first (50, 10, 5, 1), and is limited by per-denomination inventory counters. Coins inserted by customers refill the inventory, so the block sits between the vending FSM's coin total and the physical coin hopper.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/coin_inventory.sv | 37 +++
 rtl/vend_change_ctrl.sv | 118 +++++++++++
 tb/tb_vend_change_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine constants: coin values, drink codes, change-controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    // Coin denominations as they appear on the 6-bit coin buses
    localparam logic [5:0] COIN_1  = 6'd1;
    localparam logic [5:0] COIN_5  = 6'd5;
    localparam logic [5:0] COIN_10 = 6'd10;
    localparam logic [5:0] COIN_50 = 6'd50;

    // Drink selection codes used by the vending FSM
    localparam logic [2:0] TEA    = 3'b100;
    localparam logic [2:0] COKE   = 3'b101;
    localparam logic [2:0] COFFEE = 3'b110;
    localparam logic [2:0] MILK   = 3'b111;

    // Change controller states
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DISPENSE = 1'b1
    } change_state_t;

endpackage

// File: rtl/coin_inventory.sv
// Saturating up/down coin counter for one denomination.
// Latency: count updates on the edge that samples inc/dec; nonzero follows count combinationally.
// Backpressure: none; increments at full scale are dropped, decrements at zero are ignored.
//
// Ports: clk, reset (async, active-high), inc (coin refilled), dec (coin ejected),
//        count (current stock), nonzero (stock > 0).
module coin_inventory #(
    parameter int INV_W    = 5,
    parameter int INV_INIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [INV_W-1:0] count,
    output logic             nonzero
);

    localparam logic [INV_W-1:0] CNT_MAX  = '1;
    localparam logic [INV_W-1:0] CNT_INIT = INV_INIT[INV_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_INIT;
        end else begin
            // inc and dec together cancel: one coin in, one coin out
            case ({inc, dec})
                2'b10: if (count != CNT_MAX) count <= count + 1'b1;
                2'b01: if (count != '0)      count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/vend_change_ctrl.sv
// Change dispenser: greedy 50/10/5/1 selection against live coin inventory, one coin per clock.
// Latency: request accepted at E0, coins after E1..Ek, done/short/remain after Ek+1.
// Backpressure: req_ready is low for the whole dispense; requests are only sampled in IDLE.
//
// Ports: clk, reset (async, active-high), coin_in (customer coin, refills stock),
//        req_valid/req_amount/req_ready (change request handshake),
//        coin_out (ejected coin or 0), done/short/remain (end-of-request report), busy.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int INV_W    = 5,
    parameter int INV_INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] coin_in,
    input  logic       req_valid,
    input  logic [7:0] req_amount,
    output logic       req_ready,
    output logic [5:0] coin_out,
    output logic       done,
    output logic       short,
    output logic [7:0] remain,
    output logic       busy
);

    change_state_t state;
    logic [7:0]    rem;

    logic [INV_W-1:0] cnt_50, cnt_10, cnt_5, cnt_1;
    logic             nz_50, nz_10, nz_5, nz_1;
    logic             dec_50, dec_10, dec_5, dec_1;
    logic [5:0]       sel_coin;

    // Stock counts are not needed by the selector (nonzero suffices); kept as nets for debug.
    logic unused_cnt;
    assign unused_cnt = ^{cnt_50, cnt_10, cnt_5, cnt_1};

    coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_50 (
        .clk(clk), .reset(reset), .inc(coin_in == COIN_50), .dec(dec_50),
        .count(cnt_50), .nonzero(nz_50)
    );
    coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_10 (
        .clk(clk), .reset(reset), .inc(coin_in == COIN_10), .dec(dec_10),
        .count(cnt_10), .nonzero(nz_10)
    );
    coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_5 (
        .clk(clk), .reset(reset), .inc(coin_in == COIN_5), .dec(dec_5),
        .count(cnt_5), .nonzero(nz_5)
    );
    coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv_1 (
        .clk(clk), .reset(reset), .inc(coin_in == COIN_1), .dec(dec_1),
        .count(cnt_1), .nonzero(nz_1)
    );

    // Greedy priority selector; requiring d <= rem keeps rem from underflowing.
    always_comb begin
        sel_coin = '0;
        dec_50   = 1'b0;
        dec_10   = 1'b0;
        dec_5    = 1'b0;
        dec_1    = 1'b0;
        if (state == ST_DISPENSE) begin
            if (nz_50 && rem >= {2'b00, COIN_50}) begin
                sel_coin = COIN_50;
                dec_50   = 1'b1;
            end else if (nz_10 && rem >= {2'b00, COIN_10}) begin
                sel_coin = COIN_10;
                dec_10   = 1'b1;
            end else if (nz_5 && rem >= {2'b00, COIN_5}) begin
                sel_coin = COIN_5;
                dec_5    = 1'b1;
            end else if (nz_1 && rem >= {2'b00, COIN_1}) begin
                sel_coin = COIN_1;
                dec_1    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rem      <= '0;
            coin_out <= '0;
            done     <= 1'b0;
            short    <= 1'b0;
            remain   <= '0;
        end else begin
            coin_out <= '0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rem   <= req_amount;
                        state <= ST_DISPENSE;
                    end
                end
                ST_DISPENSE: begin
                    if (sel_coin != '0) begin
                        coin_out <= sel_coin;
                        rem      <= rem - {2'b00, sel_coin};
                    end else begin
                        // Nothing more can be paid: report what is left over
                        done   <= 1'b1;
                        short  <= (rem != '0);
                        remain <= rem;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state == ST_DISPENSE);

endmodule

// File: tb/tb_vend_change_ctrl.sv
module tb_vend_change_ctrl;

    logic            clk = 1'b0;
    logic [3:0]      rst;
    logic [3:0][5:0] coin_in;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_amount;
    logic [3:0]      req_ready;
    logic [3:0][5:0] coin_out;
    logic [3:0]      done;
    logic [3:0]      short_o;
    logic [3:0][7:0] remain;
    logic [3:0]      busy;

    always #5 clk = ~clk;

    // Instance 0: defaults (INIT 8), 1: INIT 2, 2: INIT 0, 3: INIT 31
    for (genvar k = 0; k < 4; k++) begin : g_dut
        vend_change_ctrl #(
            .INV_W(5),
            .INV_INIT(k == 0 ? 8 : k == 1 ? 2 : k == 2 ? 0 : 31)
        ) u_dut (
            .clk(clk), .reset(rst[k]), .coin_in(coin_in[k]),
            .req_valid(req_valid[k]), .req_amount(req_amount[k]),
            .req_ready(req_ready[k]), .coin_out(coin_out[k]), .done(done[k]),
            .short(short_o[k]), .remain(remain[k]), .busy(busy[k])
        );
    end

    typedef struct {
        logic [5:0] coin;
        logic       dn;
        logic       sh;
        logic [7:0] rm;
    } exp_t;

    exp_t exp_q[$];
    int   inv_m[4][4];
    int   den[4] = '{50, 10, 5, 1};
    int   inits[4] = '{8, 2, 0, 31};
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] inv_rd(input int u, input int di);
        case (u * 4 + di)
            0:  return g_dut[0].u_dut.u_inv_50.count;
            1:  return g_dut[0].u_dut.u_inv_10.count;
            2:  return g_dut[0].u_dut.u_inv_5.count;
            3:  return g_dut[0].u_dut.u_inv_1.count;
            4:  return g_dut[1].u_dut.u_inv_50.count;
            5:  return g_dut[1].u_dut.u_inv_10.count;
            6:  return g_dut[1].u_dut.u_inv_5.count;
            7:  return g_dut[1].u_dut.u_inv_1.count;
            8:  return g_dut[2].u_dut.u_inv_50.count;
            9:  return g_dut[2].u_dut.u_inv_10.count;
            10: return g_dut[2].u_dut.u_inv_5.count;
            11: return g_dut[2].u_dut.u_inv_1.count;
            12: return g_dut[3].u_dut.u_inv_50.count;
            13: return g_dut[3].u_dut.u_inv_10.count;
            14: return g_dut[3].u_dut.u_inv_5.count;
            default: return g_dut[3].u_dut.u_inv_1.count;
        endcase
    endfunction

    task automatic check_inv(input int u, input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s inv%0d", tag, den[i]), 32'(inv_rd(u, i)), 32'(inv_m[u][i]));
    endtask

    // Bench-side greedy model: queues the expected coin stream and the closing report
    task automatic model_req(input int u, input int amt);
        int r;
        bit found;
        r = amt;
        do begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && den[i] <= r && inv_m[u][i] > 0) begin
                    found = 1'b1;
                    inv_m[u][i]--;
                    r -= den[i];
                    exp_q.push_back('{coin: 6'(den[i]), dn: 1'b0, sh: 1'b0, rm: 8'd0});
                end
            end
        end while (found);
        exp_q.push_back('{coin: 6'd0, dn: 1'b1, sh: (r != 0), rm: 8'(r)});
    endtask

    task automatic model_refill(input int u, input int c);
        for (int i = 0; i < 4; i++)
            if (den[i] == c && inv_m[u][i] < 31) inv_m[u][i]++;
    endtask

    // Present a request to an idle instance; it is taken on the next edge (E0)
    task automatic send(input int u, input int amt);
        req_valid[u]  = 1'b1;
        req_amount[u] = 8'(amt);
        chk("ready before accept", 32'(req_ready[u]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        coin_in[u]   = '0;
    endtask

    // Pop and compare one expected entry per cycle, up to max_n entries
    task automatic drain(input int u, input string tag, input int max_n);
        exp_t e;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            @(posedge clk);
            #1;
            coin_in[u] = '0;
            n++;
            e = exp_q.pop_front();
            chk({tag, " coin_out"}, 32'(coin_out[u]), 32'(e.coin));
            chk({tag, " done"}, 32'(done[u]), 32'(e.dn));
            if (e.dn) begin
                chk({tag, " short"}, 32'(short_o[u]), 32'(e.sh));
                chk({tag, " remain"}, 32'(remain[u]), 32'(e.rm));
                chk({tag, " ready after done"}, 32'(req_ready[u]), 32'd1);
            end else begin
                chk({tag, " busy"}, 32'(busy[u]), 32'd1);
                chk({tag, " ready while busy"}, 32'(req_ready[u]), 32'd0);
            end
        end
    endtask

    initial begin
        bit saw;
        rst        = '1;
        coin_in    = '0;
        req_valid  = '0;
        req_amount = '0;
        for (int u = 0; u < 4; u++)
            for (int i = 0; i < 4; i++) inv_m[u][i] = inits[u];
        repeat (3) @(posedge clk);
        #1;
        rst = '0;

        // Reset state on every instance
        for (int u = 0; u < 4; u++) begin
            chk("rst req_ready", 32'(req_ready[u]), 32'd1);
            chk("rst coin_out", 32'(coin_out[u]), 32'd0);
            chk("rst done", 32'(done[u]), 32'd0);
            chk("rst short", 32'(short_o[u]), 32'd0);
            chk("rst remain", 32'(remain[u]), 32'd0);
            chk("rst busy", 32'(busy[u]), 32'd0);
            check_inv(u, "rst");
        end

        // 1: exact change 66 with defaults
        send(0, 66);
        model_req(0, 66);
        drain(0, "t1", 100);
        check_inv(0, "t1");

        // 2: inventory runs out, short with remain 8
        send(1, 140);
        model_req(1, 140);
        drain(1, "t2", 100);
        check_inv(1, "t2");

        // 3: empty stock, coin arriving with the request is usable on the first dispense edge
        coin_in[2] = 6'd50;
        model_refill(2, 50);
        send(2, 50);
        model_req(2, 50);
        drain(2, "t3", 100);
        send(2, 0);
        model_req(2, 0);
        drain(2, "t3 zero", 100);
        check_inv(2, "t3");

        // 4: saturation, single dispense, illegal coin, and refill+dispense cancelling
        coin_in[3] = 6'd10;
        repeat (3) begin
            @(posedge clk);
            model_refill(3, 10);
        end
        #1;
        coin_in[3] = '0;
        check_inv(3, "t4 sat");
        send(3, 10);
        model_req(3, 10);
        drain(3, "t4 req", 100);
        check_inv(3, "t4 req");
        coin_in[3] = 6'd7;
        @(posedge clk);
        #1;
        coin_in[3] = '0;
        check_inv(3, "t4 illegal");
        send(3, 10);
        coin_in[3] = 6'd10;
        model_req(3, 10);
        model_refill(3, 10);
        drain(3, "t4 net", 100);
        check_inv(3, "t4 net");

        // 5: request held during dispense is ignored until IDLE, then taken
        req_valid[0]  = 1'b1;
        req_amount[0] = 8'd66;
        @(posedge clk);
        #1;
        req_amount[0] = 8'd5;
        model_req(0, 66);
        drain(0, "t5a", 100);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("t5 accept coin_out", 32'(coin_out[0]), 32'd0);
        chk("t5 accept busy", 32'(busy[0]), 32'd1);
        model_req(0, 5);
        drain(0, "t5b", 100);
        check_inv(0, "t5");

        // 6: reset after the second coin aborts the request
        send(0, 66);
        model_req(0, 66);
        drain(0, "t6", 2);
        rst[0] = 1'b1;
        #1;
        chk("t6 coin_out", 32'(coin_out[0]), 32'd0);
        chk("t6 done", 32'(done[0]), 32'd0);
        chk("t6 req_ready", 32'(req_ready[0]), 32'd1);
        chk("t6 busy", 32'(busy[0]), 32'd0);
        for (int i = 0; i < 4; i++) inv_m[0][i] = inits[0];
        check_inv(0, "t6");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done[0] || coin_out[0] != '0) saw = 1'b1;
        end
        chk("t6 no activity after reset", 32'(saw), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
